// File: rtl/record_packer.sv
// record_packer: assembles one packed record from keyed and default field write beats
module record_packer #(
  parameter  int NUM_BYTES = 2,
  parameter  int WORD_W    = 32,
  localparam int NF        = NUM_BYTES + 1,
  localparam int REC_W     = 8 * NUM_BYTES + WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [3:0]        in_idx,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REC_W-1:0]  out_rec,
  output logic [NF-1:0]     out_missing,
  output logic              out_bad_key,
  output logic [15:0]       out_count
);
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t             state_q, state_d;
  logic               ready_q, ready_d, bad_q, bad_d, acc, is_key;
  logic [REC_W-1:0]   rec_q, rec_d;
  logic [NF-1:0]      keyed_q, keyed_d, filled_q, filled_d;
  logic [15:0]        count_q, count_d;
  assign acc    = in_valid & ready_q;
  assign is_key = in_kind == 2'd0;
  always_comb begin
    state_d  = state_q;
    rec_d    = rec_q;
    keyed_d  = keyed_q;
    filled_d = filled_q;
    bad_d    = bad_q;
    count_d  = count_q;
    if (state_q == HOLD) begin
      if (out_ready) begin
        rec_d    = '0;
        keyed_d  = '0;
        filled_d = '0;
        bad_d    = 1'b0;
        count_d  = count_q + 16'd1;
        state_d  = COLLECT;
      end
    end else if (acc) begin
      // kind bit 0 selects the byte default, bit 1 the word default; ALL_DEF has both
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (is_key && in_idx == 4'(i)) begin
          rec_d[REC_W-1-8*i -: 8] = in_data[7:0];
          keyed_d[i]  = 1'b1;
          filled_d[i] = 1'b1;
        end else if (in_kind[0] && !keyed_q[i]) begin
          rec_d[REC_W-1-8*i -: 8] = in_data[7:0];
          filled_d[i] = 1'b1;
        end
      end
      if (is_key && in_idx == 4'(NUM_BYTES)) begin
        rec_d[WORD_W-1:0]   = in_data;
        keyed_d[NUM_BYTES]  = 1'b1;
        filled_d[NUM_BYTES] = 1'b1;
      end else if (in_kind[1] && !keyed_q[NUM_BYTES]) begin
        rec_d[WORD_W-1:0]   = in_data;
        filled_d[NUM_BYTES] = 1'b1;
      end
      bad_d   = bad_q | (is_key && in_idx >= 4'(NF));
      state_d = in_last ? HOLD : COLLECT;
    end
    ready_d = state_d == COLLECT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      ready_q  <= 1'b0;
      rec_q    <= '0;
      keyed_q  <= '0;
      filled_q <= '0;
      bad_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      rec_q    <= rec_d;
      keyed_q  <= keyed_d;
      filled_q <= filled_d;
      bad_q    <= bad_d;
      count_q  <= count_d;
    end
  end
  assign in_ready    = ready_q;
  assign out_valid   = state_q == HOLD;
  assign out_rec     = rec_q;
  assign out_missing = out_valid ? ~filled_q : '0;
  assign out_bad_key = bad_q;
  assign out_count   = count_q;
endmodule

// File: tb/tb_record_packer.sv
// tb_record_packer: directed scoreboard bench for record_packer
module tb_record_packer;
  logic        clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 1;
  logic        in_ready, out_valid, out_bad_key;
  logic [1:0]  in_kind = 0;
  logic [3:0]  in_idx = 0;
  logic [31:0] in_data = 0;
  logic [47:0] out_rec;
  logic [2:0]  out_missing;
  logic [15:0] out_count;
  int total = 0, bad = 0;
  bit seen = 0;
  typedef struct {logic [47:0] rec; logic [2:0] miss; logic bk;} exp_t;
  exp_t sb[$];
  record_packer #(.NUM_BYTES(2), .WORD_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_idx(in_idx), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec),
    .out_missing(out_missing), .out_bad_key(out_bad_key), .out_count(out_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, req, $time);
    end
  endtask
  task automatic expect_rec(input logic [47:0] r, input logic [2:0] m, input logic b);
    exp_t e;
    e.rec = r; e.miss = m; e.bk = b;
    sb.push_back(e);
  endtask
  task automatic beat(input logic [1:0] k, input logic [3:0] idx, input logic [31:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    in_valid = 1; in_kind = k; in_idx = idx; in_data = d; in_last = l;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("beat_accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0; in_last = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (out_valid && n < 100) begin @(negedge clk); n++; end
    if (out_valid) chk("idle_timeout", out_valid, 0);
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_in_ready"}, in_ready, 0);
    chk({name, "_valid"}, out_valid, 0);
    chk({name, "_rec"}, out_rec, 0);
    chk({name, "_missing"}, out_missing, 0);
    chk({name, "_bad_key"}, out_bad_key, 0);
    chk({name, "_count"}, out_count, 0);
  endtask
  always @(negedge clk) begin
    if (out_valid && !seen) begin
      exp_t e;
      seen = 1;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow got_rec=%h want=none", out_rec);
      end else begin
        e = sb.pop_front();
        chk("rec", out_rec, e.rec);
        chk("missing", out_missing, e.miss);
        chk("bad_key", out_bad_key, e.bk);
      end
    end else if (!out_valid) seen = 0;
  end
  initial begin
    #12 chk_zero("reset");
    @(negedge clk); rst_n = 1;
    #1 chk("ready_pre_edge", in_ready, 0);
    @(posedge clk); #1 chk("ready_post_edge", in_ready, 1);
    expect_rec(48'h0102_0000_0003, 3'b000, 0);
    beat(0, 0, 32'h1, 0); beat(0, 1, 32'h2, 0); beat(0, 2, 32'h3, 1);
    chk("valid_latency", out_valid, 1);
    expect_rec(48'h0202_0000_0003, 3'b000, 0);
    beat(1, 0, 32'h2, 0); beat(2, 0, 32'h3, 1);
    expect_rec(48'h0303_0000_0002, 3'b000, 0);
    beat(2, 0, 32'h2, 0); beat(1, 0, 32'h3, 1);
    expect_rec(48'h0505_0000_0002, 3'b000, 0);
    beat(0, 2, 32'h2, 0); beat(1, 0, 32'h5, 1);
    expect_rec(48'h0508_0000_0009, 3'b000, 0);
    beat(1, 0, 32'h4, 0); beat(0, 1, 32'h8, 0); beat(1, 0, 32'h5, 0); beat(0, 2, 32'h9, 1);
    expect_rec(48'h0708_0000_0009, 3'b000, 0);
    beat(0, 1, 32'h8, 0); beat(0, 2, 32'h9, 0); beat(0, 0, 32'h7, 1);
    expect_rec(48'h00aa_0000_0000, 3'b101, 1);
    beat(0, 1, 32'haa, 0); beat(0, 5, 32'h1, 1);
    expect_rec(48'h4444_1122_3344, 3'b000, 0);
    beat(3, 0, 32'h1122_3344, 1);
    expect_rec(48'h5a66_0000_0066, 3'b000, 0);
    beat(0, 0, 32'h5a, 0); beat(3, 0, 32'h66, 1);
    expect_rec(48'h0000_0000_0000, 3'b111, 1);
    beat(0, 15, 32'hff, 1);
    wait_idle();
    chk("count_10", out_count, 10);
    @(negedge clk); out_ready = 0;
    expect_rec(48'h1200_0000_0000, 3'b110, 0);
    beat(0, 0, 32'h12, 1);
    expect_rec(48'h0034_0000_0000, 3'b101, 0);
    in_valid = 1; in_kind = 0; in_idx = 1; in_data = 32'h34; in_last = 1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_rec", out_rec, 48'h1200_0000_0000);
      chk("bp_count", out_count, 10);
    end
    out_ready = 1;
    @(negedge clk);
    chk("release_count", out_count, 11);
    chk("release_ready", in_ready, 1);
    chk("release_valid", out_valid, 0);
    @(posedge clk); #1 in_valid = 0; in_last = 0;
    chk("held_beat_valid", out_valid, 1);
    wait_idle();
    chk("count_12", out_count, 12);
    beat(0, 0, 32'h77, 0);
    @(negedge clk); rst_n = 0;
    #1 chk_zero("rst_mid");
    @(negedge clk); rst_n = 1;
    #1 chk("mid_ready_pre", in_ready, 0);
    @(posedge clk); #1 chk("mid_ready_post", in_ready, 1);
    out_ready = 0;
    expect_rec(48'h9900_0000_0000, 3'b110, 0);
    beat(0, 0, 32'h99, 1);
    chk("hold_valid", out_valid, 1);
    @(negedge clk); rst_n = 0;
    #1 chk_zero("rst_hold");
    @(negedge clk); rst_n = 1; out_ready = 1;
    #1 chk("hold_ready_pre", in_ready, 0);
    @(posedge clk); #1 chk("hold_ready_post", in_ready, 1);
    expect_rec(48'h0001_0000_0000, 3'b101, 0);
    beat(0, 1, 32'h1, 1);
    wait_idle();
    chk("count_after_reset", out_count, 1);
    repeat (3) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/record_packer.md
# record_packer

- Assembles one packed record from a stream of field-addressed write beats.
- Record layout: `NUM_BYTES` byte fields followed by one `WORD_W`-bit word field.
- Field resolution follows assignment-pattern precedence: keyed writes override type-default writes, and a default fills only fields not explicitly keyed.
- Sits between a configuration/command front end and any consumer of packed records; a valid/ready pair on each side decouples the two.

## Interface

Parameters:
- `NUM_BYTES`, 2, number of byte fields (1..8).
- `WORD_W`, 32, width of the word field (8..64, multiple of 8).
- Derived: `NF = NUM_BYTES+1` fields; `REC_W = 8*NUM_BYTES + WORD_W`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  write beat valid.
- `in_ready`  out  1  block accepts a beat.
- `in_kind`  in  2  0 KEY, 1 BYTE_DEF, 2 WORD_DEF, 3 ALL_DEF.
- `in_idx`  in  4  field index for KEY.
- `in_data`  in  WORD_W  write data.
- `in_last`  in  1  final beat of the record.
- `out_valid`  out  1  record available.
- `out_ready`  in  1  consumer accepts the record.
- `out_rec`  out  REC_W  packed record.
- `out_missing`  out  NF  bit i set means field i was never written (zero-filled).
- `out_bad_key`  out  1  a KEY beat in this record had `in_idx >= NF`.
- `out_count`  out  16  records delivered, wraps at 2^16.

## Operation

Record layout:
- Field i < NUM_BYTES is the byte at `out_rec[REC_W-1-8i -: 8]`; field 0 is at the MSB.
- Field `NUM_BYTES` is the word at `out_rec[WORD_W-1:0]`.

Per-field state: value, `keyed` flag, `filled` flag.

Accepted beat effects (accept = `in_valid & in_ready`):
- KEY, `in_idx < NF`:
  - Byte field: value = `in_data[7:0]`.
  - Word field: value = `in_data`.
  - Sets `keyed` and `filled`. A later KEY to the same field overwrites it.
- KEY, `in_idx >= NF`: no field change; sets sticky bad-key flag.
- BYTE_DEF: every byte field with `keyed`=0 takes `in_data[7:0]` and sets `filled`. A later default overwrites an earlier default.
- WORD_DEF: the word field, if `keyed`=0, takes `in_data` and sets `filled`.
- ALL_DEF: BYTE_DEF and WORD_DEF applied in the same beat.
- A keyed field is never changed by any default, whether the default arrives earlier or later.

States:
- COLLECT: `in_ready`=1, `out_valid`=0.
  - Accepted beat with `in_last`=1 → HOLD.
  - The last beat's effect is included in the presented record.
- HOLD: `in_ready`=0, `out_valid`=1.
  - `out_rec`, `out_missing` (= ~filled) and `out_bad_key` stay stable.
  - On `out_ready`=1: clear all field state and flags, increment `out_count`, → COLLECT.

## Timing

Reset:
- While `rst_n`=0, all outputs are 0: `in_ready`, `out_valid`, `out_rec`, `out_missing`, `out_bad_key`, `out_count`. State is COLLECT.
- `in_ready` is registered and rises on the first `clk` edge after `rst_n` deasserts.

Latency and throughput:
- Last beat accepted at edge N → `out_valid`=1 after edge N.
- Handshake at edge M → `out_valid`=0 and `in_ready`=1 after edge M.
- Minimum period: 2 cycles per single-beat record.

Boundary conditions:
- `in_valid` is ignored while `in_ready`=0; no beat is lost provided the source holds it.
- `out_ready` is ignored in COLLECT.
- Asserting `rst_n`=0 in any state, including mid-record or HOLD, discards the partial or pending record immediately.
- A record with no beats except a last beat that changes nothing is legal: all fields zero, `out_missing` all ones.

## Test plan

Defaults: NUM_BYTES=2, WORD_W=32, REC_W=48.

- KEY 0:1, KEY 1:2, KEY 2:3 (last) → `out_rec`=0x0102_0000_0003, `out_missing`=0, `out_bad_key`=0, `out_valid` one cycle after last.
- BYTE_DEF 2, WORD_DEF 3 (last) → 0x0202_0000_0003. Separately, WORD_DEF 2, BYTE_DEF 3 (last) → 0x0303_0000_0002.
- Precedence, both orders:
  - KEY 2:2, BYTE_DEF 5 (last) → 0x0505_0000_0002.
  - BYTE_DEF 4, KEY 1:8, BYTE_DEF 5, KEY 2:9 (last) → 0x0508_0000_0009.
- KEY 1:8, KEY 2:9, KEY 0:7 (last) → 0x0708_0000_0009. Then KEY 1:0xAA, KEY 5:1 (last) → 0x00AA_0000_0000, `out_missing`=3'b101, `out_bad_key`=1.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles with `in_valid`=1: `in_ready` stays 0 and the record is stable.
  - Release `out_ready`: `out_count` increments by 1 and the next record starts clean (missing all ones if empty).
- Reset: pulse `rst_n` low mid-record and again during HOLD → all outputs 0 asynchronously, and `in_ready` returns one edge after release.
